main_memory_ctrl: RTL and testbench

//  Initiator side of the main-memory port. Arbitrates line requests from IC (SRC=0), DC (SRC=1), DMA (SRC=2).

---
 rtl/main_mem_pkg.sv | 49 ++++
 rtl/rr_arbiter3.sv | 40 ++++
 rtl/main_memory_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_main_memory_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/main_mem_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// main_mem_pkg: shared types, constants and write-lane alignment helper
// Rev 1.0
// ----------------------------------------------------------------------------
package main_mem_pkg;

  localparam int LINE_W = 256;
  localparam int ADDR_W = 15;

  localparam logic [1:0] SRC_IC  = 2'd0;
  localparam logic [1:0] SRC_DC  = 2'd1;
  localparam logic [1:0] SRC_DMA = 2'd2;

  localparam logic [2:0] SIZE_LINE = 3'd0;
  localparam logic [2:0] SIZE_MAX  = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // Partial writes arrive low-aligned; move them up to their byte lane.
  // Bytes shifted beyond lane 31 fall off the top of the line.
  function automatic logic [LINE_W-1:0] align_wdata(
    input logic [LINE_W-1:0] wdata,
    input logic [4:0]        lane,
    input logic [2:0]        size
  );
    logic [LINE_W-1:0] ext;
    logic [31:0]       masked;
    logic [2:0]        nbytes;
    if (size == SIZE_LINE) begin
      return wdata;
    end
    nbytes = (size > SIZE_MAX) ? SIZE_MAX : size;
    masked = 32'd0;
    for (int b = 0; b < 4; b++) begin
      if (3'(b) < nbytes) begin
        masked[8*b +: 8] = wdata[8*b +: 8];
      end
    end
    ext = {{(LINE_W-32){1'b0}}, masked};
    return ext << {lane, 3'b000};
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter3.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rr_arbiter3: three-way round-robin arbiter, search starts after last grant
// Rev 1.0
// ----------------------------------------------------------------------------
module rr_arbiter3
  import main_mem_pkg::*;
(
  input  logic [2:0] req,
  input  logic [2:0] mask,
  input  logic [1:0] last,
  output logic [2:0] grant
);

  logic [2:0] elig;

  always_comb begin
    elig  = req & ~mask;
    grant = 3'b000;
    case (last)
      SRC_IC: begin
        if (elig[1])      grant = 3'b010;
        else if (elig[2]) grant = 3'b100;
        else if (elig[0]) grant = 3'b001;
      end
      SRC_DC: begin
        if (elig[2])      grant = 3'b100;
        else if (elig[0]) grant = 3'b001;
        else if (elig[1]) grant = 3'b010;
      end
      default: begin
        if (elig[0])      grant = 3'b001;
        else if (elig[1]) grant = 3'b010;
        else if (elig[2]) grant = 3'b100;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/main_memory_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// main_memory_ctrl: arbitrates IC/DC/DMA line requests onto the fixed-latency
// main_memory port and returns ACK plus the registered read line. Rev 1.0
// ----------------------------------------------------------------------------
module main_memory_ctrl
  import main_mem_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 5,
  parameter int unsigned CNT_W       = 3
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_ack,
  input  logic              dc_req,
  input  logic              dc_wr,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [2:0]        dc_size,
  input  logic [LINE_W-1:0] dc_wdata,
  output logic              dc_ack,
  input  logic              dma_req,
  input  logic              dma_wr,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [2:0]        dma_size,
  input  logic [LINE_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic [LINE_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic              mem_en,
  output logic [2:0]        mem_write_size,
  inout  wire  [LINE_W-1:0] mem_data_buf
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        src_q, src_d;
  logic [1:0]        last_q, last_d;
  logic              wr_q, wr_d;
  logic [2:0]        mask_q, mask_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        size_q, size_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic [LINE_W-1:0] rdata_q, rdata_d;
  logic              en_q, en_d;
  logic              mwr_q, mwr_d;
  logic              drive_q, drive_d;
  logic [2:0]        ack_q, ack_d;

  logic [2:0]        grant;
  logic [1:0]        sel_src;
  logic              sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [2:0]        sel_size;
  logic [LINE_W-1:0] sel_wdata;
  logic [CNT_W-1:0]  cnt_inc;

  rr_arbiter3 u_arb (
    .req   ({dma_req, dc_req, ic_req}),
    .mask  (mask_q),
    .last  (last_q),
    .grant (grant)
  );

  // IC is read-only, so its WR/SIZE are forced rather than taken from a port.
  always_comb begin
    sel_src   = SRC_IC;
    sel_wr    = 1'b0;
    sel_addr  = ic_addr;
    sel_size  = SIZE_LINE;
    sel_wdata = '0;
    if (grant[1]) begin
      sel_src   = SRC_DC;
      sel_wr    = dc_wr;
      sel_addr  = dc_addr;
      sel_size  = dc_size;
      sel_wdata = dc_wdata;
    end else if (grant[2]) begin
      sel_src   = SRC_DMA;
      sel_wr    = dma_wr;
      sel_addr  = dma_addr;
      sel_size  = dma_size;
      sel_wdata = dma_wdata;
    end
  end

  assign cnt_inc = cnt_q + CNT_ONE;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    src_d   = src_q;
    last_d  = last_q;
    wr_d    = wr_q;
    mask_d  = 3'b000;
    addr_d  = addr_q;
    size_d  = size_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    en_d    = en_q;
    mwr_d   = mwr_q;
    drive_d = drive_q;
    ack_d   = 3'b000;
    case (state_q)
      ST_IDLE: begin
        if (|grant) begin
          state_d = ST_ACCESS;
          cnt_d   = '0;
          src_d   = sel_src;
          wr_d    = sel_wr;
          addr_d  = sel_addr;
          size_d  = sel_size;
          wdata_d = align_wdata(sel_wdata, sel_addr[4:0], sel_size);
          en_d    = 1'b1;
          mwr_d   = sel_wr;
          drive_d = sel_wr;
        end
      end
      ST_ACCESS: begin
        if (cnt_q == LAST_CNT) begin
          state_d = ST_DONE;
          en_d    = 1'b0;
          mwr_d   = 1'b0;
          drive_d = 1'b0;
          ack_d   = 3'b001 << src_q;
          if (!wr_q) begin
            rdata_d = mem_data_buf;
          end
        end else begin
          cnt_d = cnt_inc;
          // WR drops for the final cycle while data is still held on the bus.
          mwr_d = wr_q && (cnt_inc != LAST_CNT);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        last_d  = src_q;
        mask_d  = 3'b001 << src_q;
      end
      default: begin
        state_d = ST_IDLE;
        en_d    = 1'b0;
        mwr_d   = 1'b0;
        drive_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      src_q   <= SRC_IC;
      last_q  <= SRC_DMA;
      wr_q    <= 1'b0;
      mask_q  <= 3'b000;
      addr_q  <= '0;
      size_q  <= SIZE_LINE;
      wdata_q <= '0;
      rdata_q <= '0;
      en_q    <= 1'b0;
      mwr_q   <= 1'b0;
      drive_q <= 1'b0;
      ack_q   <= 3'b000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
      last_q  <= last_d;
      wr_q    <= wr_d;
      mask_q  <= mask_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      en_q    <= en_d;
      mwr_q   <= mwr_d;
      drive_q <= drive_d;
      ack_q   <= ack_d;
    end
  end

  assign mem_data_buf   = drive_q ? wdata_q : {LINE_W{1'bz}};
  assign ic_ack         = ack_q[0];
  assign dc_ack         = ack_q[1];
  assign dma_ack        = ack_q[2];
  assign rdata          = rdata_q;
  assign mem_addr       = addr_q;
  assign mem_wr         = mwr_q;
  assign mem_en         = en_q;
  assign mem_write_size = size_q;

endmodule
`default_nettype wire

// File: tb/tb_main_memory_ctrl.sv
`default_nettype none
// tb_main_memory_ctrl: directed IC/DC/DMA requests against a behavioural
// main_memory; a queue scoreboard checks every ACK and returned read line.
module tb_main_memory_ctrl;
  import main_mem_pkg::*;

  localparam int L = 5;

  typedef struct packed {
    logic [1:0]   src;
    logic         chk;
    logic [255:0] data;
  } exp_t;

  logic         clk = 1'b0;
  logic         clr = 1'b0;
  logic         ic_req = 1'b0;
  logic [14:0]  ic_addr = '0;
  logic         ic_ack;
  logic         dc_req = 1'b0;
  logic         dc_wr = 1'b0;
  logic [14:0]  dc_addr = '0;
  logic [2:0]   dc_size = '0;
  logic [255:0] dc_wdata = '0;
  logic         dc_ack;
  logic         dma_req = 1'b0;
  logic         dma_wr = 1'b0;
  logic [14:0]  dma_addr = '0;
  logic [2:0]   dma_size = '0;
  logic [255:0] dma_wdata = '0;
  logic         dma_ack;
  logic [255:0] rdata;
  logic [14:0]  mem_addr;
  logic         mem_wr;
  logic         mem_en;
  logic [2:0]   mem_write_size;
  wire  [255:0] mem_bus;

  int checks = 0;
  int errors = 0;
  int en_cycles = 0;
  int wr_cycles = 0;
  int ack_count = 0;
  logic [255:0] last_wbus = '0;
  exp_t sb[$];

  main_memory_ctrl #(.MEM_LATENCY(L), .CNT_W(3)) dut (
    .clk(clk), .clr(clr),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_ack(ic_ack),
    .dc_req(dc_req), .dc_wr(dc_wr), .dc_addr(dc_addr), .dc_size(dc_size),
    .dc_wdata(dc_wdata), .dc_ack(dc_ack),
    .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_size(dma_size),
    .dma_wdata(dma_wdata), .dma_ack(dma_ack),
    .rdata(rdata), .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_en(mem_en),
    .mem_write_size(mem_write_size), .mem_data_buf(mem_bus)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] init_line(input int l);
    logic [255:0] v;
    for (int b = 0; b < 32; b++) v[8*b +: 8] = 8'((l * 13 + b * 7 + 90) & 255);
    return v;
  endfunction

  // Behavioural main_memory: drives read data unless this access is a write.
  logic [255:0] mem [0:1023];
  logic wr_seen = 1'b0;
  wire  mem_drv = mem_en && !mem_wr && !wr_seen;
  assign mem_bus = mem_drv ? mem[mem_addr[14:5]] : {256{1'bz}};

  initial begin : p_mem
    logic [255:0] line;
    int lane;
    int n;
    for (int l = 0; l < 1024; l++) mem[l] = init_line(l);
    forever begin
      @(negedge clk);
      if (mem_en && mem_wr) begin
        n    = (mem_write_size > 3'd4) ? 4 : int'(mem_write_size);
        lane = int'(mem_addr[4:0]);
        line = mem[mem_addr[14:5]];
        for (int b = 0; b < 32; b++)
          if (mem_write_size == 3'd0 || (b >= lane && b < lane + n))
            line[8*b +: 8] = mem_bus[8*b +: 8];
        mem[mem_addr[14:5]] = line;
      end
      wr_seen = mem_en && (mem_wr || wr_seen);
    end
  end

  initial begin : p_mon
    exp_t e;
    logic [2:0] got;
    forever begin
      @(negedge clk);
      if (mem_en) en_cycles++;
      if (mem_en && mem_wr) begin
        wr_cycles++;
        last_wbus = mem_bus;
      end
      got = {dma_ack, dc_ack, ic_ack};
      if (got != 3'b000) begin
        ack_count++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ack got=%b required=none", got);
        end else begin
          e = sb.pop_front();
          if (got != (3'b001 << e.src)) begin
            errors++;
            $display("FAIL ack_src got=%b required=%b", got, 3'b001 << e.src);
          end
          if (e.chk) begin
            checks++;
            if (rdata !== e.data) begin
              errors++;
              $display("FAIL rdata got=%h required=%h", rdata, e.data);
            end
          end
        end
      end
    end
  end

  initial begin : p_watchdog
    #200000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got=%0h required=%0h", name, got, req);
    end
  endtask

  task automatic push(input int src, input logic wr, input logic [255:0] exp_rd);
    exp_t e;
    e.src  = 2'(src);
    e.chk  = !wr;
    e.data = exp_rd;
    sb.push_back(e);
  endtask

  // Holds REQ through the IDLE cycle after ACK, so the post-DONE mask matters.
  task automatic do_req(input int src, input logic wr, input logic [14:0] addr,
                        input logic [2:0] size, input logic [255:0] wd);
    logic got;
    got = 1'b0;
    @(posedge clk); #1;
    case (src)
      0: begin ic_addr = addr; ic_req = 1'b1; end
      1: begin dc_wr = wr; dc_addr = addr; dc_size = size; dc_wdata = wd; dc_req = 1'b1; end
      default: begin dma_wr = wr; dma_addr = addr; dma_size = size; dma_wdata = wd; dma_req = 1'b1; end
    endcase
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk);
      case (src)
        0: got = ic_ack;
        1: got = dc_ack;
        default: got = dma_ack;
      endcase
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL ack_timeout src=%0d got=none required=ack", src);
    end
    @(posedge clk);
    @(posedge clk); #1;
    case (src)
      0: ic_req = 1'b0;
      1: dc_req = 1'b0;
      default: dma_req = 1'b0;
    endcase
  endtask

  task automatic txn(input int src, input logic wr, input logic [14:0] addr,
                     input logic [2:0] size, input logic [255:0] wd, input logic [255:0] exp_rd);
    push(src, wr, exp_rd);
    do_req(src, wr, addr, size, wd);
  endtask

  initial begin : p_main
    logic [255:0] pat;
    logic [255:0] e;
    logic [255:0] wd;
    int w0, e0, a0;
    logic [8:0] en_h, ack_h;

    for (int i = 0; i < 8; i++) pat[32*i +: 32] = 32'hCAFE_F00D ^ (32'h0101_0101 * 32'(i));

    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", {mem_en, mem_wr, ic_ack, dc_ack, dma_ack, mem_write_size, mem_addr}, '0);
    check("reset_rdata", rdata, '0);
    clr = 1'b1;

    // Latency profile of a single DC read
    fork
      txn(1, 1'b0, 15'h0040, 3'd0, '0, init_line(2));
      begin
        @(posedge clk); #1;
        for (int k = 0; k < 9; k++) begin
          @(negedge clk);
          en_h[k]  = mem_en;
          ack_h[k] = dc_ack;
        end
      end
    join
    check("t1_en_cycles", en_h, 9'b0_0011_1110);
    check("t1_ack_cycle", ack_h, 9'b0_0100_0000);

    // Full-line DMA write then read back
    w0 = wr_cycles;
    e0 = en_cycles;
    txn(2, 1'b1, 15'h1FE0, 3'd0, pat, '0);
    check("t2_wr_cycles", wr_cycles - w0, L - 1);
    check("t2_en_cycles", en_cycles - e0, L);
    check("t2_bus", last_wbus, pat);
    txn(2, 1'b0, 15'h1FE0, 3'd0, '0, pat);

    // Two-byte DC write at lane 3
    wd = '1;
    wd[31:0] = 32'h1234_BEEF;
    txn(1, 1'b1, 15'h0023, 3'd2, wd, '0);
    check("t3_bus", last_wbus, 256'hBEEF << 24);
    e = init_line(1);
    e[31:24] = 8'hEF;
    e[39:32] = 8'hBE;
    txn(1, 1'b0, 15'h0020, 3'd0, '0, e);

    // Four bytes at lane 31: only one survives, no wrap to lane 0
    wd = '0;
    wd[31:0] = 32'h1122_3344;
    txn(1, 1'b1, 15'h001F, 3'd4, wd, '0);
    check("t4_bus", last_wbus, 256'h44 << 248);
    e = init_line(0);
    e[255:248] = 8'h44;
    txn(1, 1'b0, 15'h0000, 3'd0, '0, e);

    // SIZE=7 behaves as four bytes
    wd = '1;
    wd[31:0] = 32'hCAFE_BABE;
    txn(2, 1'b1, 15'h0042, 3'd7, wd, '0);
    check("t5_size7_bus", last_wbus, 256'hCAFEBABE << 16);
    e = init_line(2);
    e[47:16] = 32'hCAFE_BABE;
    txn(2, 1'b0, 15'h0040, 3'd0, '0, e);

    // Simultaneous requests, last grant was DMA: IC, DC, DMA twice
    push(0, 1'b0, init_line(8));
    push(1, 1'b0, init_line(3));
    push(2, 1'b0, init_line(5));
    fork
      do_req(0, 1'b0, 15'h0100, 3'd0, '0);
      do_req(1, 1'b0, 15'h0060, 3'd0, '0);
      do_req(2, 1'b0, 15'h00A0, 3'd0, '0);
    join
    push(0, 1'b0, init_line(9));
    push(1, 1'b0, init_line(6));
    push(2, 1'b0, init_line(7));
    fork
      do_req(0, 1'b0, 15'h0120, 3'd0, '0);
      do_req(1, 1'b0, 15'h00C0, 3'd0, '0);
      do_req(2, 1'b0, 15'h00E0, 3'd0, '0);
    join

    // Reset asserted in ACCESS cycle 2 of a DC write
    a0 = ack_count;
    @(posedge clk); #1;
    dc_wr = 1'b1; dc_addr = 15'h0400; dc_size = 3'd0; dc_wdata = pat; dc_req = 1'b1;
    @(posedge clk);
    @(posedge clk); #2;
    check("t6_in_write", {mem_en, mem_wr}, 2'b11);
    clr = 1'b0;
    #1;
    check("t6_reset_ctrl", {mem_en, mem_wr, ic_ack, dc_ack, dma_ack}, '0);
    check("t6_reset_rdata", rdata, '0);
    dc_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    clr = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("t6_no_ack", ack_count, a0);
    txn(0, 1'b0, 15'h0080, 3'd0, '0, init_line(4));

    check("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
